// File: rtl/gpio_pads_in_filt.sv
// Pad-input conditioning: per-bit synchronizer, counter debounce, edge pulses and a
// sticky, maskable interrupt status with a combined irq.
module gpio_pads_in_filt #(
  parameter int unsigned OPENFRAME_IO_PADS = 6,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEB_W             = 4
) (
  input  logic                         mclk,
  input  logic                         reset_n,
  input  logic [OPENFRAME_IO_PADS-1:0] gpio_in,
  input  logic [DEB_W-1:0]             cfg_deb_limit,
  input  logic [OPENFRAME_IO_PADS-1:0] cfg_rise_en,
  input  logic [OPENFRAME_IO_PADS-1:0] cfg_fall_en,
  input  logic [OPENFRAME_IO_PADS-1:0] int_clr,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_in_sync,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_in_filt,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_rise_pulse,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_fall_pulse,
  output logic [OPENFRAME_IO_PADS-1:0] int_status,
  output logic                         irq
);

  localparam int unsigned N = OPENFRAME_IO_PADS;
  localparam logic [DEB_W-1:0] CntOne = {{(DEB_W-1){1'b0}}, 1'b1};

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [DEB_W-1:0] cnt_q  [N];
  logic [DEB_W-1:0] cnt_d  [N];
  logic [N-1:0]     filt_q, filt_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [N-1:0]     status_q, status_d;
  logic [N-1:0]     sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    filt_d = filt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < cfg_deb_limit) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else begin
        // >= rather than == so lowering the limit mid-count still terminates.
        cnt_d[i]  = '0;
        filt_d[i] = sync[i];
        rise_d[i] = sync[i];
        fall_d[i] = ~sync[i];
      end
    end
    // Status sets from the registered pulses; a set beats a same-cycle clear.
    status_d = (rise_q & cfg_rise_en) | (fall_q & cfg_fall_en) | (status_q & ~int_clr);
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      filt_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
    end
  end

  assign gpio_in_sync    = sync;
  assign gpio_in_filt    = filt_q;
  assign gpio_rise_pulse = rise_q;
  assign gpio_fall_pulse = fall_q;
  assign int_status      = status_q;
  assign irq             = |status_q;

endmodule

// File: tb/tb_gpio_pads_in_filt.sv
// Directed bench for gpio_pads_in_filt: a per-cycle vector table plus hand sequences
// for reset behaviour and reset during an in-progress debounce.
module tb_gpio_pads_in_filt;

  logic       mclk = 1'b0;
  logic       reset_n;
  logic [5:0] gpio_in, cfg_rise_en, cfg_fall_en, int_clr;
  logic [3:0] cfg_deb_limit;
  logic [5:0] gpio_in_sync, gpio_in_filt, gpio_rise_pulse, gpio_fall_pulse, int_status;
  logic       irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  gpio_pads_in_filt #(
    .OPENFRAME_IO_PADS(6),
    .SYNC_STAGES      (2),
    .DEB_W            (4)
  ) dut (
    .mclk           (mclk),
    .reset_n        (reset_n),
    .gpio_in        (gpio_in),
    .cfg_deb_limit  (cfg_deb_limit),
    .cfg_rise_en    (cfg_rise_en),
    .cfg_fall_en    (cfg_fall_en),
    .int_clr        (int_clr),
    .gpio_in_sync   (gpio_in_sync),
    .gpio_in_filt   (gpio_in_filt),
    .gpio_rise_pulse(gpio_rise_pulse),
    .gpio_fall_pulse(gpio_fall_pulse),
    .int_status     (int_status),
    .irq            (irq)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [5:0] gin;
    logic [5:0] clr;
    logic [3:0] lim;
    logic [5:0] ren;
    logic [5:0] fen;
    logic [5:0] e_sync;
    logic [5:0] e_filt;
    logic [5:0] e_rise;
    logic [5:0] e_fall;
    logic [5:0] e_stat;
    logic       e_irq;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [5:0] s, input logic [5:0] f,
                         input logic [5:0] r, input logic [5:0] fl, input logic [5:0] st,
                         input logic iq);
    chk({tag, ".sync"}, gpio_in_sync, s);
    chk({tag, ".filt"}, gpio_in_filt, f);
    chk({tag, ".rise"}, gpio_rise_pulse, r);
    chk({tag, ".fall"}, gpio_fall_pulse, fl);
    chk({tag, ".status"}, int_status, st);
    chk({tag, ".irq"}, {5'b0, irq}, {5'b0, iq});
  endtask

  initial begin
    // Pads 0/1: L=3 step on pad 0 and 2-cycle glitch on pad 1, then clear pad 0 status.
    tbl[0]  = '{6'h01, 6'h00, 4'd3, 6'h03, 6'h02, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[1]  = '{6'h01, 6'h00, 4'd3, 6'h03, 6'h02, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[2]  = '{6'h03, 6'h00, 4'd3, 6'h03, 6'h02, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[3]  = '{6'h03, 6'h00, 4'd3, 6'h03, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[4]  = '{6'h01, 6'h00, 4'd3, 6'h03, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[5]  = '{6'h01, 6'h00, 4'd3, 6'h03, 6'h02, 6'h01, 6'h01, 6'h01, 6'h00, 6'h00, 1'b0};
    tbl[6]  = '{6'h01, 6'h00, 4'd3, 6'h03, 6'h02, 6'h01, 6'h01, 6'h00, 6'h00, 6'h01, 1'b1};
    tbl[7]  = '{6'h01, 6'h00, 4'd3, 6'h03, 6'h02, 6'h01, 6'h01, 6'h00, 6'h00, 6'h01, 1'b1};
    tbl[8]  = '{6'h01, 6'h01, 4'd3, 6'h03, 6'h02, 6'h01, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0};
    // Pad 2: L=0, fall-only enable, 0->1->0, then clear.
    tbl[9]  = '{6'h05, 6'h00, 4'd0, 6'h00, 6'h04, 6'h01, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[10] = '{6'h05, 6'h00, 4'd0, 6'h00, 6'h04, 6'h05, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[11] = '{6'h01, 6'h00, 4'd0, 6'h00, 6'h04, 6'h05, 6'h05, 6'h04, 6'h00, 6'h00, 1'b0};
    tbl[12] = '{6'h01, 6'h00, 4'd0, 6'h00, 6'h04, 6'h01, 6'h05, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[13] = '{6'h01, 6'h00, 4'd0, 6'h00, 6'h04, 6'h01, 6'h01, 6'h00, 6'h04, 6'h00, 1'b0};
    tbl[14] = '{6'h01, 6'h00, 4'd0, 6'h00, 6'h04, 6'h01, 6'h01, 6'h00, 6'h00, 6'h04, 1'b1};
    tbl[15] = '{6'h01, 6'h04, 4'd0, 6'h00, 6'h04, 6'h01, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[16] = '{6'h01, 6'h00, 4'd0, 6'h00, 6'h04, 6'h01, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0};
    // Pad 3: clear strobe coincident with the enabled rise pulse; set must win.
    tbl[17] = '{6'h09, 6'h00, 4'd0, 6'h08, 6'h04, 6'h01, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[18] = '{6'h09, 6'h00, 4'd0, 6'h08, 6'h04, 6'h09, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[19] = '{6'h09, 6'h00, 4'd0, 6'h08, 6'h04, 6'h09, 6'h09, 6'h08, 6'h00, 6'h00, 1'b0};
    tbl[20] = '{6'h09, 6'h08, 4'd0, 6'h08, 6'h04, 6'h09, 6'h09, 6'h00, 6'h00, 6'h08, 1'b1};
    tbl[21] = '{6'h09, 6'h00, 4'd0, 6'h08, 6'h04, 6'h09, 6'h09, 6'h00, 6'h00, 6'h08, 1'b1};
    tbl[22] = '{6'h09, 6'h08, 4'd0, 6'h08, 6'h04, 6'h09, 6'h09, 6'h00, 6'h00, 6'h00, 1'b0};

    reset_n = 1'b0;
    gpio_in = 6'h3F;
    cfg_deb_limit = 4'd3;
    cfg_rise_en = 6'h00;
    cfg_fall_en = 6'h00;
    int_clr = 6'h00;

    // Reset held with all pads high: everything stays zero.
    for (int c = 0; c < 3; c++) begin
      step();
      chk_all($sformatf("rst%0d", c), 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);
    end
    reset_n = 1'b1;
    step();
    chk("rel1.sync", gpio_in_sync, 6'h00);
    step();
    chk("rel2.sync", gpio_in_sync, 6'h3F);

    reset_n = 1'b0;
    gpio_in = 6'h00;
    step();
    step();
    chk_all("rst_again", 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);
    reset_n = 1'b1;

    for (int v = 0; v < 23; v++) begin
      gpio_in       = tbl[v].gin;
      int_clr       = tbl[v].clr;
      cfg_deb_limit = tbl[v].lim;
      cfg_rise_en   = tbl[v].ren;
      cfg_fall_en   = tbl[v].fen;
      step();
      chk_all($sformatf("vec%0d", v), tbl[v].e_sync, tbl[v].e_filt, tbl[v].e_rise,
              tbl[v].e_fall, tbl[v].e_stat, tbl[v].e_irq);
    end

    // Reset while pad 4 has counted to 2 of L=5; afterwards a full L+1 period is needed.
    gpio_in = 6'h19;
    int_clr = 6'h00;
    cfg_deb_limit = 4'd5;
    cfg_rise_en = 6'h00;
    cfg_fall_en = 6'h00;
    for (int c = 0; c < 4; c++) step();
    chk("pre_rst.filt", gpio_in_filt, 6'h09);
    reset_n = 1'b0;
    step();
    chk_all("mid_rst", 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);
    reset_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      chk($sformatf("post_rst%0d.filt", c), gpio_in_filt, 6'h00);
      chk($sformatf("post_rst%0d.rise", c), gpio_rise_pulse, 6'h00);
    end
    step();
    chk("post_rst_done.filt", gpio_in_filt, 6'h19);
    chk("post_rst_done.rise", gpio_rise_pulse, 6'h19);
    chk("post_rst_done.fall", gpio_fall_pulse, 6'h00);
    step();
    chk("post_rst_after.rise", gpio_rise_pulse, 6'h00);
    chk("post_rst_after.status", int_status, 6'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
